// File: rtl/ext_irq_ctrl.sv
// ext_irq_ctrl: external interrupt controller. This is a memory-mapped bus slave.
// It gathers up to 32 asynchronous interrupt sources. Each source is synchronised
// and latched as either edge-type or level-type pending state. The pending state
// is masked by ENABLE. A CLAIM register returns the lowest pending enabled source.
//
// Ports
//   Clk, Rst              clock, synchronous active-high reset
//   req, we, addr, be,
//   wdata                 bus request, already decoded by the bus mux
//   gnt                   grant; this is req passed through combinationally
//   rvalid, rdata, err    response, one cycle after the grant
//   src                   asynchronous active-high interrupt sources
//   irq_o                 registered OR of (PENDING & ENABLE), goes to the core
//
// Register map (byte offset from the base address)
//   0x00 PENDING  R/W1C
//   0x04 ENABLE   RW
//   0x08 MODE     RW; 1 = rising edge, 0 = level
//   0x0C CLAIM    R; returns idx+1 of the lowest pending enabled source, or 0
//   0x10 RAW      R; synchronised source levels
//   other offsets return err=1 with rdata=0
module ext_irq_ctrl #(
  parameter int          NUM_SRC   = 16,
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               req,
  input  logic               we,
  input  logic [31:0]        addr,
  input  logic [3:0]         be,
  input  logic [31:0]        wdata,
  output logic               gnt,
  output logic               rvalid,
  output logic [31:0]        rdata,
  output logic               err,
  input  logic [NUM_SRC-1:0] src,
  output logic               irq_o
);

  logic [NUM_SRC-1:0] s1_q, s2_q, s3_q;
  logic [NUM_SRC-1:0] pend_q, pend_d, en_q, en_d, mode_q, mode_d;
  logic               rvalid_q, err_q, err_d, irq_q;
  logic [31:0]        rdata_q, rdata_d;

  logic               acc;
  logic [7:0]         off;
  logic [5:0]         idx;
  logic [31:0]        bm, wr_bits;
  logic [NUM_SRC-1:0] pe, rise, clr, claim_oh;
  logic [5:0]         claim_id;
  logic [31:0]        pend32, en32, mode32, raw32, rmux;

  // The bus mux qualifies req on the upper address bits. Only the low byte is decoded here.
  assign gnt     = req;
  assign acc     = req & ~Rst;
  assign off     = addr[7:0] - ADDR_BASE[7:0];
  assign idx     = off[7:2];
  assign bm      = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  assign wr_bits = wdata & bm;

  logic unused_bits;
  assign unused_bits = ^{addr, off[1:0], wdata, bm, wr_bits};

  assign pe   = pend_q & en_q;
  assign rise = s2_q & ~s3_q;

  // Lowest index wins. Scan from the top so that the last hit is the lowest index.
  always_comb begin
    claim_id = '0;
    claim_oh = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (pe[i]) begin
        claim_id    = 6'(i + 1);
        claim_oh    = '0;
        claim_oh[i] = 1'b1;
      end
    end
  end

  // Zero-extended register views. Bits at NUM_SRC and above read as 0.
  always_comb begin
    pend32 = '0;  pend32[NUM_SRC-1:0] = pend_q;
    en32   = '0;  en32[NUM_SRC-1:0]   = en_q;
    mode32 = '0;  mode32[NUM_SRC-1:0] = mode_q;
    raw32  = '0;  raw32[NUM_SRC-1:0]  = s2_q;
  end

  always_comb begin
    case (idx)
      6'd0:    rmux = pend32;
      6'd1:    rmux = en32;
      6'd2:    rmux = mode32;
      6'd3:    rmux = {26'd0, claim_id};
      6'd4:    rmux = raw32;
      default: rmux = '0;
    endcase
  end

  assign rdata_d = (acc & ~we) ? rmux : '0;
  assign err_d   = acc & (idx > 6'd4);

  // A clear can come from a W1C write, or from a CLAIM read returning that bit.
  // The mode mux below ignores the clear for level sources.
  always_comb begin
    clr = '0;
    if (acc & we & (idx == 6'd0))
      clr = wr_bits[NUM_SRC-1:0];
    if (acc & ~we & (idx == 6'd3))
      clr = claim_oh;
  end

  // Edge: a new rise overrides a same-cycle clear. Level: follow s2.
  // The current MODE is used here, so a MODE write takes effect on the following cycle.
  assign pend_d = (mode_q & ((pend_q & ~clr) | rise)) | (~mode_q & s2_q);

  always_comb begin
    en_d   = en_q;
    mode_d = mode_q;
    if (acc & we & (idx == 6'd1))
      en_d = (en_q & ~bm[NUM_SRC-1:0]) | wr_bits[NUM_SRC-1:0];
    if (acc & we & (idx == 6'd2))
      mode_d = (mode_q & ~bm[NUM_SRC-1:0]) | wr_bits[NUM_SRC-1:0];
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      s1_q     <= '0;
      s2_q     <= '0;
      s3_q     <= '0;
      pend_q   <= '0;
      en_q     <= '0;
      mode_q   <= '0;
      irq_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      s1_q     <= src;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      pend_q   <= pend_d;
      en_q     <= en_d;
      mode_q   <= mode_d;
      irq_q    <= |pe;
      rvalid_q <= acc;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;
  assign err    = err_q;
  assign irq_o  = irq_q;

endmodule

// File: tb/tb_ext_irq_ctrl.sv
// Testbench for ext_irq_ctrl. It uses four kinds of stimulus:
//   - a table of bus vectors with constant expectations
//   - hand-written multi-cycle sequences (edge, level, priority, collision, reset)
//   - a randomized phase
//   - a cycle-level reference model of the register rules, which checks every
//     cycle's response and irq_o
module tb_ext_irq_ctrl;
  localparam int N = 16;

  logic          Clk = 1'b0;
  logic          Rst = 1'b1;
  logic          req = 1'b0, we = 1'b0;
  logic [31:0]   addr = '0, wdata = '0;
  logic [3:0]    be = '0;
  logic [N-1:0]  src = '0;
  logic          gnt, rvalid, err, irq_o;
  logic [31:0]   rdata;

  int n_vec = 0, n_err = 0;

  ext_irq_ctrl #(.NUM_SRC(N), .ADDR_BASE(32'h0)) dut (
    .Clk(Clk), .Rst(Rst), .req(req), .we(we), .addr(addr), .be(be),
    .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .err(err),
    .src(src), .irq_o(irq_o)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model. It works from the register rules, with the synchroniser as a
  // three-deep history of sampled src.
  localparam logic [31:0] MASK = 32'h0000_FFFF;
  logic [31:0] m_pend = '0, m_en = '0, m_mode = '0, m_rdata = '0;
  logic        m_rv = 1'b0, m_err = 1'b0, m_irq = 1'b0;
  logic [N-1:0] hist [3] = '{default: '0};
  logic [31:0] m_pe, m_clr, m_s2, m_s3, m_bm, m_oldmode;
  logic [7:0]  m_off;
  int          m_claim;

  always @(posedge Clk) begin
    if (Rst) begin
      m_pend = '0; m_en = '0; m_mode = '0; m_rdata = '0;
      m_rv = 1'b0; m_err = 1'b0; m_irq = 1'b0;
      hist = '{default: '0};
    end else begin
      m_s2 = {16'h0, hist[1]};
      m_s3 = {16'h0, hist[2]};
      m_pe = m_pend & m_en;
      m_oldmode = m_mode;
      m_claim = 0;
      for (int i = 0; i < N; i++)
        if (m_pe[i] && m_claim == 0) m_claim = i + 1;
      m_bm  = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
      m_off = addr[7:0] & 8'hFC;
      m_rv  = req;
      m_err = req && (m_off > 8'h10);
      m_rdata = '0;
      m_clr = '0;
      if (req && !we) begin
        case (m_off)
          8'h00: m_rdata = m_pend;
          8'h04: m_rdata = m_en;
          8'h08: m_rdata = m_mode;
          8'h0C: m_rdata = 32'(m_claim);
          8'h10: m_rdata = m_s2;
          default: m_rdata = '0;
        endcase
        if (m_off == 8'h0C && m_claim != 0) m_clr[m_claim-1] = 1'b1;
      end
      if (req && we) begin
        case (m_off)
          8'h00: m_clr  = wdata & m_bm;
          8'h04: m_en   = ((m_en & ~m_bm) | (wdata & m_bm)) & MASK;
          8'h08: m_mode = ((m_mode & ~m_bm) | (wdata & m_bm)) & MASK;
          default: ;
        endcase
      end
      m_irq = |m_pe;
      for (int i = 0; i < N; i++)
        m_pend[i] = m_oldmode[i] ? ((m_pend[i] & ~m_clr[i]) | (m_s2[i] & ~m_s3[i])) : m_s2[i];
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = src;
    end
  end

  // Every cycle, compare the DUT against the model.
  always @(posedge Clk) begin
    #1;
    chk("model_rvalid", {31'h0, rvalid}, {31'h0, m_rv});
    chk("model_irq", {31'h0, irq_o}, {31'h0, m_irq});
    if (m_rv) begin
      chk("model_rdata", rdata, m_rdata);
      chk("model_err", {31'h0, err}, {31'h0, m_err});
    end
  end

  task automatic rd_chk(input string nm, input logic [7:0] off, input logic [31:0] exp);
    @(negedge Clk);
    req = 1'b1; we = 1'b0; addr = {24'h0, off}; be = 4'h0; wdata = '0;
    #1 chk({nm, "_gnt"}, {31'h0, gnt}, 32'h1);
    @(negedge Clk);
    req = 1'b0;
    chk({nm, "_rvalid"}, {31'h0, rvalid}, 32'h1);
    chk(nm, rdata, exp);
  endtask

  task automatic wr(input logic [7:0] off, input logic [3:0] b, input logic [31:0] d);
    @(negedge Clk);
    req = 1'b1; we = 1'b1; addr = {24'h0, off}; be = b; wdata = d;
    @(negedge Clk);
    req = 1'b0; we = 1'b0;
    chk("wr_rvalid", {31'h0, rvalid}, 32'h1);
    chk("wr_err", {31'h0, err}, 32'h0);
  endtask

  typedef struct {
    logic        we;
    logic [7:0]  off;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t tbl[$];

  initial begin
    tbl.push_back('{1'b0, 8'h00, 4'h0, 32'h0, 32'h0, 1'b0});
    tbl.push_back('{1'b0, 8'h04, 4'h0, 32'h0, 32'h0, 1'b0});
    tbl.push_back('{1'b0, 8'h08, 4'h0, 32'h0, 32'h0, 1'b0});
    tbl.push_back('{1'b0, 8'h0C, 4'h0, 32'h0, 32'h0, 1'b0});
    tbl.push_back('{1'b0, 8'h10, 4'h0, 32'h0, 32'h0, 1'b0});
    tbl.push_back('{1'b1, 8'h04, 4'b0001, 32'hFFFF_FFFF, 32'h0, 1'b0});
    tbl.push_back('{1'b0, 8'h04, 4'h0, 32'h0, 32'h0000_00FF, 1'b0});
    tbl.push_back('{1'b1, 8'h04, 4'hF, 32'hFFFF_FFFF, 32'h0, 1'b0});
    tbl.push_back('{1'b0, 8'h04, 4'h0, 32'h0, 32'h0000_FFFF, 1'b0});
    tbl.push_back('{1'b1, 8'h08, 4'b0011, 32'h1234_5678, 32'h0, 1'b0});
    tbl.push_back('{1'b0, 8'h08, 4'h0, 32'h0, 32'h0000_5678, 1'b0});
    tbl.push_back('{1'b0, 8'h20, 4'h0, 32'h0, 32'h0, 1'b1});
    tbl.push_back('{1'b1, 8'h14, 4'hF, 32'hFFFF_FFFF, 32'h0, 1'b1});
    tbl.push_back('{1'b0, 8'hFC, 4'h0, 32'h0, 32'h0, 1'b1});
    tbl.push_back('{1'b1, 8'h0C, 4'hF, 32'hFFFF_FFFF, 32'h0, 1'b0});
    tbl.push_back('{1'b1, 8'h10, 4'hF, 32'hFFFF_FFFF, 32'h0, 1'b0});
    tbl.push_back('{1'b1, 8'h04, 4'hF, 32'h0, 32'h0, 1'b0});
    tbl.push_back('{1'b1, 8'h08, 4'hF, 32'h0, 32'h0, 1'b0});
    tbl.push_back('{1'b0, 8'h04, 4'h0, 32'h0, 32'h0, 1'b0});
    tbl.push_back('{1'b0, 8'h08, 4'h0, 32'h0, 32'h0, 1'b0});

    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("reset_irq", {31'h0, irq_o}, 32'h0);
    chk("reset_rvalid", {31'h0, rvalid}, 32'h0);
    Rst = 1'b0;

    // Table: back-to-back requests. Each response is checked in the following cycle.
    for (int k = 0; k <= tbl.size(); k++) begin
      @(negedge Clk);
      if (k > 0) begin
        chk("tbl_rvalid", {31'h0, rvalid}, 32'h1);
        chk("tbl_rdata", rdata, tbl[k-1].exp_rd);
        chk("tbl_err", {31'h0, err}, {31'h0, tbl[k-1].exp_err});
      end
      if (k < tbl.size()) begin
        req = 1'b1; we = tbl[k].we; addr = {24'h0, tbl[k].off};
        be = tbl[k].be; wdata = tbl[k].wdata;
        #1 chk("tbl_gnt", {31'h0, gnt}, 32'h1);
      end else begin
        req = 1'b0; we = 1'b0;
      end
    end
    @(posedge Clk); #1 chk("tbl_rvalid_drop", {31'h0, rvalid}, 32'h0);

    // Edge source 0: latency to irq_o, then claim, then no re-pend while held high.
    wr(8'h08, 4'hF, 32'h1);
    wr(8'h04, 4'hF, 32'h1);
    src[0] = 1'b1;
    repeat (3) @(posedge Clk);
    #1 chk("edge_irq_e3", {31'h0, irq_o}, 32'h0);
    @(posedge Clk);
    #1 chk("edge_irq_e4", {31'h0, irq_o}, 32'h1);
    rd_chk("edge_claim", 8'h0C, 32'h1);
    chk("edge_irq_hold", {31'h0, irq_o}, 32'h1);
    @(posedge Clk);
    #1 chk("edge_irq_fall", {31'h0, irq_o}, 32'h0);
    rd_chk("edge_pend0", 8'h00, 32'h0);
    repeat (5) @(posedge Clk);
    rd_chk("edge_norepend", 8'h00, 32'h0);

    // Level source 3.
    src = '0;
    wr(8'h08, 4'hF, 32'h0);
    wr(8'h04, 4'hF, 32'h8);
    src[3] = 1'b1;
    repeat (4) @(posedge Clk);
    rd_chk("lvl_pend", 8'h00, 32'h8);
    wr(8'h00, 4'hF, 32'h8);
    rd_chk("lvl_w1c", 8'h00, 32'h8);
    @(negedge Clk);
    src[3] = 1'b0;
    repeat (3) @(posedge Clk);
    #1 chk("lvl_irq_e3", {31'h0, irq_o}, 32'h1);
    @(posedge Clk);
    #1 chk("lvl_irq_e4", {31'h0, irq_o}, 32'h0);
    rd_chk("lvl_pend_clr", 8'h00, 32'h0);

    // Priority: sources 1, 2 and 5 are edge-type; source 1 is disabled.
    wr(8'h08, 4'hF, 32'h26);
    wr(8'h04, 4'hF, 32'h24);
    @(negedge Clk);
    src = 16'h0026;
    repeat (4) @(posedge Clk);
    @(negedge Clk);
    src = '0;
    rd_chk("prio_claim_a", 8'h0C, 32'd3);
    rd_chk("prio_claim_b", 8'h0C, 32'd6);
    rd_chk("prio_claim_c", 8'h0C, 32'd0);
    rd_chk("prio_pend", 8'h00, 32'h2);
    wr(8'h00, 4'hF, 32'h2);
    rd_chk("prio_pend_clr", 8'h00, 32'h0);

    // A W1C and a new rising edge in the same cycle: the set wins.
    wr(8'h08, 4'hF, 32'h1);
    wr(8'h04, 4'hF, 32'h1);
    src[0] = 1'b1;
    @(posedge Clk);
    @(posedge Clk);
    @(negedge Clk);
    req = 1'b1; we = 1'b1; addr = 32'h0; be = 4'hF; wdata = 32'h1;
    @(negedge Clk);
    req = 1'b0; we = 1'b0;
    chk("coll_rvalid", {31'h0, rvalid}, 32'h1);
    rd_chk("coll_pend", 8'h00, 32'h1);
    src = '0;

    // Reset asserted during an outstanding access drops the response.
    @(negedge Clk);
    req = 1'b1; we = 1'b0; addr = 32'h4; Rst = 1'b1;
    #1 chk("rst_gnt", {31'h0, gnt}, 32'h1);
    @(posedge Clk);
    #1 chk("rst_rvalid", {31'h0, rvalid}, 32'h0);
    @(negedge Clk);
    req = 1'b0; Rst = 1'b0;
    rd_chk("rst_en", 8'h04, 32'h0);
    rd_chk("rst_pend", 8'h00, 32'h0);

    // Randomized phase. Only the model checks this phase.
    for (int c = 0; c < 600; c++) begin
      @(negedge Clk);
      if ($urandom_range(3) == 0) src = src ^ (16'h1 << $urandom_range(N - 1));
      req   = 1'($urandom_range(1));
      we    = 1'($urandom_range(1));
      addr  = {24'h0, 8'($urandom_range(7) * 4)};
      be    = 4'($urandom_range(15));
      wdata = ($urandom_range(1) == 1) ? $urandom : 32'($urandom_range(255));
      Rst   = ($urandom_range(99) == 0);
    end
    @(negedge Clk);
    req = 1'b0; Rst = 1'b0;
    repeat (3) @(posedge Clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running, want finished");
    $fatal(1);
  end
endmodule
